save_point_bank: RTL and testbench

//  Bank of N_SAVES save points for one room. Each point has its own trigger FSM with a

---
 rtl/save_point_bank_pkg.sv | 35 +++
 rtl/save_point_bank_fsm.sv | 75 +++++++
 rtl/save_point_bank_rom.sv | 28 ++
 rtl/save_point_bank.sv | 168 ++++++++++++++++
 tb/tb_save_point_bank.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/save_point_bank_pkg.sv
// Shared types and helpers for the save-point bank.
//  save_state_t    : per-channel trigger state
//  TRANSPARENT_RGB : texel value that marks a see-through sprite pixel
//  ROM_AW          : sprite ROM address width (32x32 texels)
//  in_range()      : 11-bit half-open compare with a lower bound clamped at zero
//  texel()         : contents of the save (unsaved) / saved sprite images
package save_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    LIT   = 2'd2
  } save_state_t;

  localparam logic [11:0] TRANSPARENT_RGB = 12'hFFF;
  localparam int          ROM_AW          = 10;

  // v in [lo, hi). A negative lo (position minus margin near the screen edge)
  // clamps to zero instead of wrapping to a huge unsigned value.
  function automatic logic in_range(input logic [10:0] v, input int lo, input int hi);
    int lo_c;
    int vi;
    lo_c = (lo < 0) ? 0 : lo;
    vi   = int'(v);
    return (vi >= lo_c) && (vi < hi);
  endfunction

  // Sprite image: the rightmost texel column is transparent, the rest is an
  // address-derived pattern, distinct for the saved and unsaved images.
  function automatic logic [11:0] texel(input logic saved, input logic [ROM_AW-1:0] addr);
    if (addr[4:0] == 5'd31) return TRANSPARENT_RGB;
    return saved ? ({2'b01, addr} ^ 12'h35A) : ({2'b00, addr} ^ 12'h0A5);
  endfunction

endpackage

// File: rtl/save_point_bank_fsm.sv
// Trigger FSM of one save point.
//  clk, rst   : clock, asynchronous active-high reset
//  frame_tick : one pulse per video frame, advances the flash counter
//  trig       : this channel commits a save (enter FLASH)
//  clear      : another channel commits (return to IDLE)
//  state      : IDLE / FLASH / LIT
//  img_sel    : 1 = draw saved image, 0 = draw unsaved image
module save_point_fsm
  import save_pkg::*;
#(
  parameter int FLASH_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        trig,
  input  logic        clear,
  output save_state_t state,
  output logic        img_sel
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);

  save_state_t   state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A frame_tick arriving in the trigger cycle is not counted: the count
  // starts with the channel already in FLASH.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state_next = FLASH;
            cnt_next   = '0;
          end
        end
        FLASH: begin
          if (frame_tick) begin
            cnt_next = cnt + CW'(1);
            if (cnt == CW'(FLASH_FRAMES - 1)) state_next = LIT;
          end
        end
        LIT:     state_next = LIT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Flashing alternates every 4 frames, starting on the saved image.
  always_comb begin
    case (state)
      LIT:     img_sel = 1'b1;
      FLASH:   img_sel = ~cnt[2];
      default: img_sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/save_point_bank_rom.sv
// Synchronous sprite ROM, one-cycle read latency.
//  clk  : clock
//  addr : texel address
//  q    : texel colour, registered
module save_rom
  import save_pkg::*;
#(
  parameter bit SAVED = 1'b0
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [11:0]       q
);

  logic [11:0] mem [2**ROM_AW];

  genvar gi;
  generate
    for (gi = 0; gi < 2**ROM_AW; gi++) begin : g_img
      assign mem[gi] = texel(SAVED, ROM_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    q <= mem[addr];
  end

endmodule

// File: rtl/save_point_bank.sv
// Bank of save points for one room: trigger arbitration, respawn point and
// sprite rendering through a shared unsaved/saved ROM pair.
//  clk, rst          : clock, asynchronous active-high reset
//  frame_tick        : one pulse per video frame
//  col, row          : raster position
//  kid_x, kid_y      : kid reference point
//  save_key          : save button (used when TRIG_MODE=1)
//  is_button         : opaque sprite pixel, 1-cycle latency
//  button_rgb        : sprite colour, 1-cycle latency, 0 outside sprites
//  spawn_x, spawn_y  : respawn coordinates
//  active_idx        : active save index, N_SAVES when none
//  save_pulse        : one-cycle pulse per committed save
module save_point_bank
  import save_pkg::*;
#(
  parameter int                    N_SAVES      = 4,
  parameter int                    SAVE_W       = 32,
  parameter int                    SAVE_H       = 32,
  parameter int                    MARGIN_X     = 3,
  parameter int                    MARGIN_Y     = 7,
  parameter logic [10*N_SAVES-1:0] POS_X        = {10'd120, 10'd300, 10'd200, 10'd100},
  parameter logic [10*N_SAVES-1:0] POS_Y        = {10'd110, 10'd300, 10'd300, 10'd100},
  parameter logic [9:0]            SPAWN_X0     = 10'd40,
  parameter logic [9:0]            SPAWN_Y0     = 10'd400,
  parameter int                    FLASH_FRAMES = 32,
  parameter int                    TRIG_MODE    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic [9:0]  kid_x,
  input  logic [9:0]  kid_y,
  input  logic        save_key,
  output logic        is_button,
  output logic [11:0] button_rgb,
  output logic [9:0]  spawn_x,
  output logic [9:0]  spawn_y,
  output logic [2:0]  active_idx,
  output logic        save_pulse
);

  save_state_t       ch_state [N_SAVES];
  logic [ROM_AW-1:0] ch_addr  [N_SAVES];
  logic [9:0]        ch_sx    [N_SAVES];
  logic [9:0]        ch_sy    [N_SAVES];
  logic [N_SAVES-1:0] img_sel;
  logic [N_SAVES-1:0] trig_req;
  logic [N_SAVES-1:0] in_box;
  logic [N_SAVES-1:0] trig;
  logic [N_SAVES-1:0] clear;

  logic              win_any;
  logic [2:0]        win_idx;
  logic [9:0]        win_sx;
  logic [9:0]        win_sy;
  logic              hit_any;
  logic [ROM_AW-1:0] rom_addr;
  logic              hit_sel;
  logic              in_box_d;
  logic              sel_d;
  logic [11:0]       rgb_unsaved;
  logic [11:0]       rgb_saved;
  logic [11:0]       rgb_pix;

  genvar gi;
  generate
    for (gi = 0; gi < N_SAVES; gi++) begin : g_ch
      localparam int PX = int'(POS_X[10*gi +: 10]);
      localparam int PY = int'(POS_Y[10*gi +: 10]);

      // Only an IDLE channel may trigger, so standing on the active save is harmless.
      assign trig_req[gi] = in_range({1'b0, kid_x}, PX - MARGIN_X, PX + SAVE_W + MARGIN_X) &&
                            in_range({1'b0, kid_y}, PY - MARGIN_Y, PY + SAVE_H + MARGIN_Y) &&
                            ((TRIG_MODE == 0) || save_key) &&
                            (ch_state[gi] == IDLE);

      assign in_box[gi]  = in_range({1'b0, col}, PX, PX + SAVE_W) &&
                           in_range({1'b0, row}, PY, PY + SAVE_H);
      assign ch_addr[gi] = ROM_AW'((int'(col) - PX) + (int'(row) - PY) * SAVE_W);
      assign ch_sx[gi]   = 10'(PX);
      assign ch_sy[gi]   = 10'(PY + SAVE_H - 1);

      // The winner's commit returns every other channel to IDLE on the same edge.
      assign trig[gi]  = win_any && (win_idx == 3'(gi));
      assign clear[gi] = win_any && (win_idx != 3'(gi));

      save_point_fsm #(
        .FLASH_FRAMES(FLASH_FRAMES)
      ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .trig      (trig[gi]),
        .clear     (clear[gi]),
        .state     (ch_state[gi]),
        .img_sel   (img_sel[gi])
      );
    end
  endgenerate

  // Priority encoders: scanning downward leaves the lowest index in place.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_sx  = '0;
    win_sy  = '0;
    for (int k = N_SAVES - 1; k >= 0; k--) begin
      if (trig_req[k]) begin
        win_any = 1'b1;
        win_idx = 3'(k);
        win_sx  = ch_sx[k];
        win_sy  = ch_sy[k];
      end
    end
  end

  always_comb begin
    hit_any  = 1'b0;
    rom_addr = '0;
    hit_sel  = 1'b0;
    for (int k = N_SAVES - 1; k >= 0; k--) begin
      if (in_box[k]) begin
        hit_any  = 1'b1;
        rom_addr = ch_addr[k];
        hit_sel  = img_sel[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spawn_x    <= SPAWN_X0;
      spawn_y    <= SPAWN_Y0;
      active_idx <= 3'(N_SAVES);
      save_pulse <= 1'b0;
      in_box_d   <= 1'b0;
      sel_d      <= 1'b0;
    end else begin
      save_pulse <= win_any;
      if (win_any) begin
        spawn_x    <= win_sx;
        spawn_y    <= win_sy;
        active_idx <= win_idx;
      end
      in_box_d <= hit_any;
      sel_d    <= hit_sel;
    end
  end

  save_rom #(.SAVED(1'b0)) u_rom_unsaved (
    .clk (clk),
    .addr(rom_addr),
    .q   (rgb_unsaved)
  );

  save_rom #(.SAVED(1'b1)) u_rom_saved (
    .clk (clk),
    .addr(rom_addr),
    .q   (rgb_saved)
  );

  assign rgb_pix    = sel_d ? rgb_saved : rgb_unsaved;
  assign is_button  = in_box_d && (rgb_pix != TRANSPARENT_RGB);
  assign button_rgb = in_box_d ? rgb_pix : 12'h000;

endmodule

// File: tb/tb_save_point_bank.sv
// Randomized bench for save_point_bank: two instances (overlap trigger, and
// overlap+save_key trigger with a sprite at the screen corner) against a
// reference model of active save, flash progress and sprite image.
module tb_save_point_bank;

  localparam int N = 4;
  localparam logic [39:0] PXA = {10'd120, 10'd300, 10'd200, 10'd100};
  localparam logic [39:0] PYA = {10'd110, 10'd300, 10'd300, 10'd100};
  localparam logic [39:0] PXB = {10'd900, 10'd600, 10'd500, 10'd0};
  localparam logic [39:0] PYB = {10'd470, 10'd200, 10'd200, 10'd2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] col = '0, row = '0;
  logic [9:0] kx_a = '0, ky_a = '0, kx_b = '0, ky_b = '0;
  logic       key_a = 1'b0, key_b = 1'b0;

  logic        btn_a, btn_b, pulse_a, pulse_b;
  logic [11:0] rgb_a, rgb_b;
  logic [9:0]  sx_a, sy_a, sx_b, sy_b;
  logic [2:0]  act_a, act_b;

  always #5 clk = ~clk;

  save_point_bank #(.POS_X(PXA), .POS_Y(PYA), .TRIG_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .col(col), .row(row),
    .kid_x(kx_a), .kid_y(ky_a), .save_key(key_a),
    .is_button(btn_a), .button_rgb(rgb_a), .spawn_x(sx_a), .spawn_y(sy_a),
    .active_idx(act_a), .save_pulse(pulse_a)
  );

  save_point_bank #(.POS_X(PXB), .POS_Y(PYB), .TRIG_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .col(col), .row(row),
    .kid_x(kx_b), .kid_y(ky_b), .save_key(key_b),
    .is_button(btn_b), .button_rgb(rgb_b), .spawn_x(sx_b), .spawn_y(sy_b),
    .active_idx(act_b), .save_pulse(pulse_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus for the next cycle
  bit s_rst = 1'b1;
  int s_kx[2], s_ky[2];
  bit s_key[2];
  int s_col = 0, s_row = 0;
  int frame_cnt = 0;

  // reference model: active save, flash progress, spawn, expected outputs
  int m_active[2], m_ticks[2], m_sx[2], m_sy[2];
  bit m_lit[2], e_pulse[2], e_btn[2];
  int e_rgb[2];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int px(input int i, input int k);
    logic [39:0] v;
    v = (i == 0) ? PXA : PXB;
    return int'(v[10*k +: 10]);
  endfunction

  function automatic int py(input int i, input int k);
    logic [39:0] v;
    v = (i == 0) ? PYA : PYB;
    return int'(v[10*k +: 10]);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Sprite image contents: column 31 transparent, otherwise a fixed pattern.
  function automatic int tex(input bit saved, input int a);
    if (a % 32 == 31) return 'hFFF;
    return saved ? ((a + 1024) ^ 'h35A) : (a ^ 'h0A5);
  endfunction

  task automatic model_reset(input int i);
    m_active[i] = N;
    m_ticks[i]  = 0;
    m_lit[i]    = 1'b0;
    m_sx[i]     = 40;
    m_sy[i]     = 400;
    e_pulse[i]  = 1'b0;
    e_btn[i]    = 1'b0;
    e_rgb[i]    = 0;
  endtask

  // Predicts the outputs seen after the next rising edge from the inputs just driven.
  task automatic model_step(input int i);
    int win, hit, p_x, p_y, a, c;
    bit sv;
    if (s_rst) begin
      model_reset(i);
      return;
    end
    win = -1;
    hit = -1;
    for (int k = 0; k < N; k++) begin
      p_x = px(i, k);
      p_y = py(i, k);
      if (win < 0 && k != m_active[i] && (i == 0 || s_key[i]) &&
          s_kx[i] >= imax(0, p_x - 3) && s_kx[i] < p_x + 35 &&
          s_ky[i] >= imax(0, p_y - 7) && s_ky[i] < p_y + 39) win = k;
      if (hit < 0 && s_col >= p_x && s_col < p_x + 32 && s_row >= p_y && s_row < p_y + 32) hit = k;
    end
    if (hit >= 0) begin
      if (hit == m_active[i]) sv = m_lit[i] || ((m_ticks[i] / 4) % 2 == 0);
      else sv = 1'b0;
      a = (s_col - px(i, hit)) + (s_row - py(i, hit)) * 32;
      c = tex(sv, a);
      e_btn[i] = (c != 'hFFF);
      e_rgb[i] = c;
    end else begin
      e_btn[i] = 1'b0;
      e_rgb[i] = 0;
    end
    e_pulse[i] = (win >= 0);
    if (win >= 0) begin
      m_active[i] = win;
      m_ticks[i]  = 0;
      m_lit[i]    = 1'b0;
      m_sx[i]     = px(i, win);
      m_sy[i]     = py(i, win) + 31;
      $display("[TB] inst %0d save commit ch %0d spawn (%0d,%0d) at %0t", i, win, m_sx[i], m_sy[i], $time);
    end else if (m_active[i] < N && !m_lit[i] && frame_tick) begin
      m_ticks[i]++;
      if (m_ticks[i] == 32) m_lit[i] = 1'b1;
    end
  endtask

  task automatic check_all();
    check("a_active", int'(act_a), m_active[0]);
    check("a_spawn_x", int'(sx_a), m_sx[0]);
    check("a_spawn_y", int'(sy_a), m_sy[0]);
    check("a_pulse", int'(pulse_a), int'(e_pulse[0]));
    check("a_is_button", int'(btn_a), int'(e_btn[0]));
    check("a_rgb", int'(rgb_a), e_rgb[0]);
    check("b_active", int'(act_b), m_active[1]);
    check("b_spawn_x", int'(sx_b), m_sx[1]);
    check("b_spawn_y", int'(sy_b), m_sy[1]);
    check("b_pulse", int'(pulse_b), int'(e_pulse[1]));
    check("b_is_button", int'(btn_b), int'(e_btn[1]));
    check("b_rgb", int'(rgb_b), e_rgb[1]);
  endtask

  task automatic rand_raster();
    int r, i, k;
    r = $urandom_range(0, 19);
    if (r == 0) begin
      s_col = 1023;
      s_row = $urandom_range(0, 1023);
    end else if (r < 8) begin
      s_col = $urandom_range(0, 1023);
      s_row = $urandom_range(0, 1023);
    end else begin
      i = $urandom_range(0, 1);
      k = $urandom_range(0, N - 1);
      s_col = (px(i, k) - 2 + $urandom_range(0, 35)) & 1023;
      s_row = (py(i, k) - 2 + $urandom_range(0, 35)) & 1023;
    end
  endtask

  task automatic pick_kid(input int i);
    int k, p_x, p_y, cx, cy;
    k   = $urandom_range(0, N - 1);
    p_x = px(i, k);
    p_y = py(i, k);
    cx  = p_x + 16;
    cy  = p_y + 16;
    case ($urandom_range(0, 11))
      0:       begin cx = 1015; cy = 1015; end
      1:       ;
      2:       cx = imax(0, p_x - 3) - 1;
      3:       cx = imax(0, p_x - 3);
      4:       cx = p_x + 34;
      5:       cx = p_x + 35;
      6:       cy = imax(0, p_y - 7) - 1;
      7:       cy = imax(0, p_y - 7);
      8:       cy = p_y + 38;
      9:       cy = p_y + 39;
      10:      begin cx = 125; cy = 120; end
      default: begin cx = $urandom_range(0, 1023); cy = $urandom_range(0, 1023); end
    endcase
    s_kx[i] = cx & 1023;
    s_ky[i] = cy & 1023;
    s_key[i] = ($urandom_range(0, 1) == 1);
  endtask

  // One clock: check the previous edge's results, drive new inputs, predict.
  task automatic cycle();
    @(negedge clk);
    check_all();
    frame_cnt++;
    rst        = s_rst;
    frame_tick = (frame_cnt % 8 == 0);
    col  = 10'(s_col);
    row  = 10'(s_row);
    kx_a = 10'(s_kx[0]);
    ky_a = 10'(s_ky[0]);
    kx_b = 10'(s_kx[1]);
    ky_b = 10'(s_ky[1]);
    key_a = s_key[0];
    key_b = s_key[1];
    model_step(0);
    model_step(1);
  endtask

  // Reset raised between edges must clear outputs without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_a_active", int'(act_a), N);
    check("async_a_spawn", int'({sx_a, sy_a}), int'({10'd40, 10'd400}));
    check("async_a_outs", int'({btn_a, rgb_a, pulse_a}), 0);
    check("async_b_active", int'(act_b), N);
    check("async_b_outs", int'({btn_b, rgb_b, pulse_b}), 0);
    model_reset(0);
    model_reset(1);
    s_rst = 1'b1;
    repeat (3) begin rand_raster(); cycle(); end
    s_rst = 1'b0;
  endtask

  initial begin
    int hold;
    int rx[5];
    int ry[5];
    model_reset(0);
    model_reset(1);
    s_kx = '{1015, 1015};
    s_ky = '{1015, 1015};
    s_key = '{1'b0, 1'b0};
    rx = '{99, 100, 131, 1023, 0};
    ry = '{100, 100, 100, 2, 2};

    repeat (3) cycle();
    s_rst = 1'b0;

    // raster edge points, then a long idle stretch with the kid far away
    for (int j = 0; j < 5; j++) begin
      s_col = rx[j];
      s_row = ry[j];
      cycle();
    end
    repeat (1000) begin rand_raster(); cycle(); end

    // kid on ch1 (mode-1 instance also overlaps its ch1, key released)
    s_kx[0] = 210; s_ky[0] = 305;
    s_kx[1] = 510; s_ky[1] = 205; s_key[1] = 1'b0;
    repeat (300) begin rand_raster(); cycle(); end

    // move to ch2 while ch1 is lit
    s_kx[0] = 310; s_ky[0] = 305;
    repeat (300) begin rand_raster(); cycle(); end

    // overlap ch0 and ch3 at once; press the key on the mode-1 instance
    s_kx[0] = 125; s_ky[0] = 120;
    s_key[1] = 1'b1;
    repeat (100) begin rand_raster(); cycle(); end

    hold = 0;
    for (int n = 0; n < 6000; n++) begin
      if (hold == 0) begin
        pick_kid(0);
        pick_kid(1);
        hold = $urandom_range(1, 60);
      end
      hold--;
      if (n == 2000 || n == 4500) async_reset();
      rand_raster();
      cycle();
    end
    @(negedge clk);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
